// File: rtl/booth_pkg.sv
// Shared types and sizing for the radix-4 Booth sequential multiplier.
// The operand stage is fixed at 8-bit operands with a 10-bit partial sum.
package booth_pkg;

  localparam int WIDTH  = 8;
  localparam int SUM_W  = WIDTH + 2;
  localparam int PROD_W = 2 * WIDTH;
  localparam int N_ITER = WIDTH / 2;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // one: add +/-M, two: add +/-2M, neg: subtract instead of add
  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_sel_t;

  function automatic booth_sel_t booth_decode(input logic [2:0] triplet);
    booth_sel_t sel;
    sel.one = triplet[1] ^ triplet[0];
    sel.two = (triplet == 3'b011) || (triplet == 3'b100);
    // 3'b111 selects zero, so it must not invert
    sel.neg = triplet[2] && !(triplet[1] && triplet[0]);
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mul_operand.sv
// Booth operand stage: selects 0/+-M/+-2M from the triplet and adds it to the
// sign-extended accumulator, producing the 10-bit partial sum.
module booth_r4_seq_mul_operand
  import booth_pkg::*;
(
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       multi,
  output logic [SUM_W-1:0] sum
);

  booth_sel_t       sel;
  logic [SUM_W-1:0] m_ext;
  logic [SUM_W-1:0] acc_ext;
  logic [SUM_W-1:0] mag;
  logic [SUM_W-1:0] addend;

  assign sel     = booth_decode(multi);
  assign m_ext   = {{(SUM_W-WIDTH){data1[WIDTH-1]}}, data1};
  assign acc_ext = {{(SUM_W-WIDTH){data2[WIDTH-1]}}, data2};

  // Magnitude mux per bit: either M or M shifted left by one.
  generate
    for (genvar gi = 0; gi < SUM_W; gi++) begin : g_mag
      if (gi == 0) begin : g_lsb
        assign mag[gi] = sel.one & m_ext[gi];
      end else begin : g_bit
        assign mag[gi] = (sel.one & m_ext[gi]) | (sel.two & m_ext[gi-1]);
      end
    end
  endgenerate

  // Negation as invert plus carry-in folded into the add.
  assign addend = mag ^ {SUM_W{sel.neg}};
  assign sum    = acc_ext + addend + {{(SUM_W-1){1'b0}}, sel.neg};

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative signed 8x8 radix-4 Booth multiplier: one Booth digit per cycle,
// valid/ready handshakes on both the request and the product side.
module booth_r4_seq_mul
  import booth_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  multiplicand_i,
  input  logic [WIDTH-1:0]  multiplier_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PROD_W-1:0] product_o,
  output logic              busy_o
);

  state_e              state_reg, state_next;
  logic [WIDTH-1:0]    m_reg, m_next;
  logic [WIDTH-1:0]    acc_reg, acc_next;
  logic [WIDTH-1:0]    q_reg, q_next;
  logic                qm1_reg, qm1_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [PROD_W-1:0]   out_reg, out_next;

  logic [2:0]          triplet;
  logic [SUM_W-1:0]    sum;

  assign triplet = {q_reg[1:0], qm1_reg};

  booth_r4_seq_mul_operand u_operand (
    .data1 (m_reg),
    .data2 (acc_reg),
    .multi (triplet),
    .sum   (sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      qm1_reg   <= 1'b0;
      cnt_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      qm1_reg   <= qm1_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    qm1_next   = qm1_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          m_next     = multiplicand_i;
          q_next     = multiplier_i;
          acc_next   = '0;
          qm1_next   = 1'b0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        // Arithmetic shift right by two: high sum bits back into acc,
        // low sum bits enter the top of the multiplier shift register.
        acc_next = sum[SUM_W-1:2];
        q_next   = {sum[1:0], q_reg[WIDTH-1:2]};
        qm1_next = q_reg[1];
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == CNT_W'(N_ITER - 1)) begin
          out_next   = {sum, q_reg[WIDTH-1:2]};
          state_next = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_reg == IDLE);
    valid_o = (state_reg == DONE);
    busy_o  = (state_reg == CALC) || (state_reg == DONE);
  end

  assign product_o = out_reg;

endmodule
